// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with majority voting, run-time parity,
// error flags and a valid/accept holding register.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    input  logic                 Rx,
    input  logic                 Tick,
    input  logic                 ParityEn,
    input  logic                 ParityOdd,
    input  logic                 RxAccept,
    output logic                 RxValid,
    output logic [DATA_BITS-1:0] RxData,
    output logic                 ParityErr,
    output logic                 FrameErr,
    output logic                 Overrun
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE - 3);
    localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE - 2);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state;
    logic                 rx_meta, rx_s, s0, s1, par_en, par_odd, par_err, frm_err;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 maj, done;

    // third vote is the live sample taken on the bit's final tick
    assign maj  = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign done = Tick && state == STOP && tick_cnt == T_LAST && bit_cnt == S_LAST;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            s0       <= 1'b1;
            s1       <= 1'b1;
            par_en   <= 1'b0;
            par_odd  <= 1'b0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
        end else if (Tick) begin
            if (tick_cnt == T_S0) s0 <= rx_s;
            if (tick_cnt == T_S1) s1 <= rx_s;
            case (state)
                IDLE: if (!rx_s) begin
                    state    <= START;
                    tick_cnt <= '0;
                end
                START: if (tick_cnt == T_HALF) begin
                    tick_cnt <= '0;
                    if (rx_s) state <= IDLE;
                    else begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        par_en  <= ParityEn;
                        par_odd <= ParityOdd;
                        par_err <= 1'b0;
                        frm_err <= 1'b0;
                    end
                end else tick_cnt <= tick_cnt + 1'b1;
                default: if (tick_cnt == T_LAST) begin
                    tick_cnt <= '0;
                    if (state == DATA) begin
                        shift   <= {maj, shift[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt == B_LAST ? '0 : bit_cnt + 1'b1;
                        if (bit_cnt == B_LAST) state <= par_en ? PARITY : STOP;
                    end else if (state == PARITY) begin
                        par_err <= (^shift ^ maj) != par_odd;
                        state   <= STOP;
                    end else begin
                        frm_err <= frm_err | ~maj;
                        bit_cnt <= bit_cnt == S_LAST ? '0 : bit_cnt + 1'b1;
                        if (bit_cnt == S_LAST) state <= IDLE;
                    end
                end else tick_cnt <= tick_cnt + 1'b1;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            RxValid   <= 1'b0;
            RxData    <= '0;
            ParityErr <= 1'b0;
            FrameErr  <= 1'b0;
            Overrun   <= 1'b0;
        end else begin
            Overrun <= done && RxValid && !RxAccept;
            if (done && (!RxValid || RxAccept)) begin
                RxValid   <= 1'b1;
                RxData    <= shift;
                ParityErr <= par_err;
                FrameErr  <= frm_err | ~maj;
            end else if (RxAccept) RxValid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed frames against an 8-bit/16x receiver and a
// 5-bit/8x/2-stop receiver; Tick every 4 Clocks.
module tb_uart_rx_param;
    logic       Clock = 1'b0, ResetN, Rx, ParityEn, ParityOdd, RxAccept;
    logic       RxValid, ParityErr, FrameErr, Overrun;
    logic [7:0] RxData;
    logic       rx_b, accept_b, valid_b, pe_b, fe_b, ovr_b;
    logic [4:0] data_b;
    logic [1:0] div = 2'd0;
    logic       Tick, hit;
    int         checks = 0, errors = 0, ovr_cnt = 0, base;

    always #5 Clock = ~Clock;
    always @(posedge Clock) div <= div + 2'd1;
    assign Tick = div == 2'd3;
    always @(negedge Clock) if (Overrun) ovr_cnt <= ovr_cnt + 1;

    uart_rx_param dut (
        .Clock(Clock), .ResetN(ResetN), .Rx(Rx), .Tick(Tick),
        .ParityEn(ParityEn), .ParityOdd(ParityOdd), .RxAccept(RxAccept),
        .RxValid(RxValid), .RxData(RxData), .ParityErr(ParityErr),
        .FrameErr(FrameErr), .Overrun(Overrun)
    );

    uart_rx_param #(.DATA_BITS(5), .OVERSAMPLE(8), .STOP_BITS(2)) dut_b (
        .Clock(Clock), .ResetN(ResetN), .Rx(rx_b), .Tick(Tick),
        .ParityEn(ParityEn), .ParityOdd(ParityOdd), .RxAccept(accept_b),
        .RxValid(valid_b), .RxData(data_b), .ParityErr(pe_b),
        .FrameErr(fe_b), .Overrun(ovr_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic sel_b, input logic v, input int ticks);
        if (sel_b) rx_b = v;
        else Rx = v;
        repeat (ticks * 4) @(negedge Clock);
    endtask

    // gbit selects a data bit that gets a one-tick inverted glitch near its centre
    task automatic send_frame(input logic sel_b, input int nbits, input int os, input logic [8:0] data,
                              input logic has_par, input logic par, input int nstop,
                              input logic [1:0] stop_v, input int gbit);
        drive(sel_b, 1'b0, os);
        for (int i = 0; i < nbits; i++)
            if (i == gbit) begin
                drive(sel_b, data[i], os / 2 - 1);
                drive(sel_b, ~data[i], 1);
                drive(sel_b, data[i], os / 2);
            end else drive(sel_b, data[i], os);
        if (has_par) drive(sel_b, par, os);
        for (int s = 0; s < nstop; s++) drive(sel_b, stop_v[s], os);
        drive(sel_b, 1'b1, 0);
    endtask

    task automatic accept_a();
        RxAccept = 1'b1;
        @(negedge Clock);
        RxAccept = 1'b0;
    endtask

    initial begin
        ResetN = 1'b0; Rx = 1'b1; rx_b = 1'b1; ParityEn = 1'b0; ParityOdd = 1'b0;
        RxAccept = 1'b0; accept_b = 1'b0; hit = 1'b0;
        repeat (3) @(negedge Clock);
        check("rst_valid", RxValid, 0);
        check("rst_data", RxData, 0);
        check("rst_perr", ParityErr, 0);
        check("rst_ferr", FrameErr, 0);
        check("rst_ovr", Overrun, 0);
        check("rst_valid_b", valid_b, 0);
        ResetN = 1'b1;
        drive(0, 1'b1, 4);

        send_frame(0, 8, 16, 9'hA5, 0, 0, 1, 2'b11, -1);
        check("8n1_valid", RxValid, 1);
        check("8n1_data", RxData, 8'hA5);
        check("8n1_perr", ParityErr, 0);
        check("8n1_ferr", FrameErr, 0);
        accept_a();
        check("8n1_accept", RxValid, 0);
        check("8n1_hold", RxData, 8'hA5);

        ParityEn = 1'b1;
        send_frame(0, 8, 16, 9'h03, 1, 0, 1, 2'b11, -1);
        check("8e1_ok_valid", RxValid, 1);
        check("8e1_ok_data", RxData, 8'h03);
        check("8e1_ok_perr", ParityErr, 0);
        accept_a();
        send_frame(0, 8, 16, 9'h03, 1, 1, 1, 2'b11, -1);
        check("8e1_bad_data", RxData, 8'h03);
        check("8e1_bad_perr", ParityErr, 1);
        accept_a();
        ParityEn = 1'b0;

        Rx = 1'b0;
        repeat (12) @(negedge Clock);
        drive(0, 1'b1, 40);
        check("false_start", RxValid, 0);
        send_frame(0, 8, 16, 9'h5A, 0, 0, 1, 2'b11, 1);
        check("glitch_valid", RxValid, 1);
        check("glitch_data", RxData, 8'h5A);
        accept_a();

        base = ovr_cnt;
        send_frame(0, 8, 16, 9'h7E, 0, 0, 1, 2'b00, -1);
        drive(0, 1'b1, 200);
        check("ferr_valid", RxValid, 1);
        check("ferr_data", RxData, 8'h7E);
        check("ferr_flag", FrameErr, 1);
        check("ferr_perr", ParityErr, 0);
        check("ferr_no_spurious", ovr_cnt - base, 0);
        accept_a();

        base = ovr_cnt;
        send_frame(0, 8, 16, 9'h11, 0, 0, 1, 2'b11, -1);
        send_frame(0, 8, 16, 9'h22, 0, 0, 1, 2'b11, -1);
        drive(0, 1'b1, 4);
        check("ovr_valid", RxValid, 1);
        check("ovr_data", RxData, 8'h11);
        check("ovr_pulses", ovr_cnt - base, 1);
        accept_a();

        base = ovr_cnt;
        send_frame(0, 8, 16, 9'h11, 0, 0, 1, 2'b11, -1);
        fork
            send_frame(0, 8, 16, 9'h22, 0, 0, 1, 2'b11, -1);
            for (int i = 0; i < 1000 && !hit; i++) begin
                @(negedge Clock);
                if (dut.done) begin
                    hit = 1'b1;
                    accept_a();
                end
            end
        join
        drive(0, 1'b1, 4);
        check("acc_done_seen", hit, 1);
        check("acc_valid", RxValid, 1);
        check("acc_data", RxData, 8'h22);
        check("acc_no_ovr", ovr_cnt - base, 0);

        drive(0, 1'b0, 88);
        #3 ResetN = 1'b0;
        #1;
        check("async_rst_valid", RxValid, 0);
        check("async_rst_data", RxData, 0);
        Rx = 1'b1;
        repeat (3) @(negedge Clock);
        ResetN = 1'b1;
        base = ovr_cnt;
        drive(0, 1'b1, 40);
        check("rst_discard", RxValid, 0);
        send_frame(0, 8, 16, 9'h3C, 0, 0, 1, 2'b11, -1);
        check("post_rst_valid", RxValid, 1);
        check("post_rst_data", RxData, 8'h3C);
        check("post_rst_ferr", FrameErr, 0);
        check("post_rst_no_ovr", ovr_cnt - base, 0);
        accept_a();

        send_frame(1, 5, 8, 9'h15, 0, 0, 2, 2'b11, -1);
        check("b_valid", valid_b, 1);
        check("b_data", data_b, 5'h15);
        check("b_ferr", fe_b, 0);
        accept_b = 1'b1;
        @(negedge Clock);
        accept_b = 1'b0;
        check("b_accept", valid_b, 0);
        send_frame(1, 5, 8, 9'h0A, 0, 0, 2, 2'b01, -1);
        drive(1, 1'b1, 100);
        check("b_stop2_valid", valid_b, 1);
        check("b_stop2_data", data_b, 5'h0A);
        check("b_stop2_ferr", fe_b, 1);
        check("a_idle", RxValid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
